// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: RV32I opcode constants, dispatch op codes and the
// packed decoded-entry layout used by the decoder and the decode queue.
package decode_queue_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0] LUIOP    = 7'b0110111;
  localparam logic [6:0] AUIPCOP  = 7'b0010111;
  localparam logic [6:0] JALOP    = 7'b1101111;
  localparam logic [6:0] JALROP   = 7'b1100111;
  localparam logic [6:0] BRANCHOP = 7'b1100011;
  localparam logic [6:0] LOADOP   = 7'b0000011;
  localparam logic [6:0] STOREOP  = 7'b0100011;
  localparam logic [6:0] CALCIOP  = 7'b0010011;
  localparam logic [6:0] CALCOP   = 7'b0110011;

  // Op 0 is reserved for "no operation / unknown encoding".
  typedef enum logic [5:0] {
    OP_NONE = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             r1;
    logic             r2;
    logic [31:0]      imm;
    logic             is_mem;
    logic             illegal;
  } dec_t;

  typedef struct packed {
    dec_t        dec;
    logic [31:0] pc;
    logic [31:0] btb_pc;
    logic        btb_predict;
  } entry_t;

endpackage

// File: rtl/rv32i_decode_comb.sv
// Combinational RV32I decoder: instruction word in, zero-filled decoded entry out.
// DECODE_ILLEGAL_EN: illegal encodings become a flagged ADDI x0,x0,0 instead of op 0.
module rv32i_decode_comb
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic             bad;
  dec_t             d;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign f3     = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign f7     = inst_i[31:25];

  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'h000};
  assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_sh = {27'd0, inst_i[24:20]};

  always_comb begin
    d   = '0;
    bad = 1'b0;
    case (opcode)
      LUIOP:   begin d.op = OP_LUI;   d.rd = rd; d.imm = imm_u; end
      AUIPCOP: begin d.op = OP_AUIPC; d.rd = rd; d.imm = imm_u; end
      JALOP:   begin d.op = OP_JAL;   d.rd = rd; d.imm = imm_j; end
      JALROP: begin
        d.op = OP_JALR; d.rd = rd; d.rs1 = rs1; d.r1 = 1'b1; d.imm = imm_i;
      end
      BRANCHOP: begin
        d.rs1 = rs1; d.rs2 = rs2; d.r1 = 1'b1; d.r2 = 1'b1; d.imm = imm_b;
        case (f3)
          3'd0:    d.op = OP_BEQ;
          3'd1:    d.op = OP_BNE;
          3'd4:    d.op = OP_BLT;
          3'd5:    d.op = OP_BGE;
          3'd6:    d.op = OP_BLTU;
          3'd7:    d.op = OP_BGEU;
          default: bad = 1'b1;
        endcase
      end
      LOADOP: begin
        d.rd = rd; d.rs1 = rs1; d.r1 = 1'b1; d.imm = imm_i; d.is_mem = 1'b1;
        case (f3)
          3'd0:    d.op = OP_LB;
          3'd1:    d.op = OP_LH;
          3'd2:    d.op = OP_LW;
          3'd4:    d.op = OP_LBU;
          3'd5:    d.op = OP_LHU;
          default: bad = 1'b1;
        endcase
      end
      STOREOP: begin
        d.rs1 = rs1; d.rs2 = rs2; d.r1 = 1'b1; d.r2 = 1'b1; d.imm = imm_s; d.is_mem = 1'b1;
        case (f3)
          3'd0:    d.op = OP_SB;
          3'd1:    d.op = OP_SH;
          3'd2:    d.op = OP_SW;
          default: bad = 1'b1;
        endcase
      end
      CALCIOP: begin
        d.rd = rd; d.rs1 = rs1; d.r1 = 1'b1; d.imm = imm_i;
        case (f3)
          3'd0: d.op = OP_ADDI;
          3'd2: d.op = OP_SLTI;
          3'd3: d.op = OP_SLTIU;
          3'd4: d.op = OP_XORI;
          3'd6: d.op = OP_ORI;
          3'd7: d.op = OP_ANDI;
          3'd1: begin
            d.op = OP_SLLI; d.imm = imm_sh;
            bad  = (f7 != 7'h00);
          end
          default: begin
            d.imm = imm_sh;
            if (f7 == 7'h00)      d.op = OP_SRLI;
            else if (f7 == 7'h20) d.op = OP_SRAI;
            else                  bad = 1'b1;
          end
        endcase
      end
      CALCOP: begin
        d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.r1 = 1'b1; d.r2 = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: d.op = OP_ADD;
          {7'h20, 3'd0}: d.op = OP_SUB;
          {7'h00, 3'd1}: d.op = OP_SLL;
          {7'h00, 3'd2}: d.op = OP_SLT;
          {7'h00, 3'd3}: d.op = OP_SLTU;
          {7'h00, 3'd4}: d.op = OP_XOR;
          {7'h00, 3'd5}: d.op = OP_SRL;
          {7'h20, 3'd5}: d.op = OP_SRA;
          {7'h00, 3'd6}: d.op = OP_OR;
          {7'h00, 3'd7}: d.op = OP_AND;
          default:       bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
`ifdef DECODE_ILLEGAL_EN
      d         = '0;
      d.op      = OP_ADDI;
      d.illegal = 1'b1;
`else
      d = '0;
`endif
    end
  end

  assign dec_o = d;

endmodule

// File: rtl/decode_queue.sv
// Decode stage FIFO between the IQ and dispatch, with per-unit dispatch release
// and single-cycle flush. DECODE_ILLEGAL_EN selects illegal-encoding flagging.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ROB_clear,
  input  logic        IQ_flag,
  input  logic [31:0] IQ_inst,
  input  logic [31:0] IQ_PC,
  input  logic [31:0] IQ_BTB_PC,
  input  logic        IQ_BTB_predict,
  output logic        Dec_flag,
  output logic        Dis_valid,
  output logic        Dis_fire,
  output logic [5:0]  Dis_op,
  output logic [4:0]  Dis_rd,
  output logic [4:0]  Dis_rs1,
  output logic [4:0]  Dis_rs2,
  output logic        Dis_R1,
  output logic        Dis_R2,
  output logic [31:0] Dis_imm,
  output logic [31:0] Dis_PC,
  output logic [31:0] Dis_BTB_PC,
  output logic        Dis_BTB_predict,
  output logic        Dis_is_mem,
  output logic        Dis_illegal,
  input  logic        RS_full,
  input  logic        LSB_full,
  input  logic        ROB_full
);

  localparam int CNT_W = PTR_W + 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  dec_t             dec_w;
  entry_t           head_e;
  logic             push, pop;

  rv32i_decode_comb u_dec (
    .inst_i (IQ_inst),
    .dec_o  (dec_w)
  );

  assign Dis_valid = (count_q != '0);
  assign head_e    = Dis_valid ? mem_q[head_q] : '0;

  // Reset is gated in here so both handshakes read 0 while it is held.
  assign pop  = rdy_in & ~rst_in & Dis_valid & ~ROB_clear & ~ROB_full
              & (head_e.dec.is_mem ? ~LSB_full : ~RS_full);
  assign push = rdy_in & ~rst_in & IQ_flag & ~ROB_clear
              & ((count_q < CNT_W'(DEPTH)) | pop);

  assign Dec_flag = push;
  assign Dis_fire = pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (ROB_clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[tail_q] <= '{dec: dec_w, pc: IQ_PC, btb_pc: IQ_BTB_PC, btb_predict: IQ_BTB_predict};
  end

  assign Dis_op          = head_e.dec.op;
  assign Dis_rd          = head_e.dec.rd;
  assign Dis_rs1         = head_e.dec.rs1;
  assign Dis_rs2         = head_e.dec.rs2;
  assign Dis_R1          = head_e.dec.r1;
  assign Dis_R2          = head_e.dec.r2;
  assign Dis_imm         = head_e.dec.imm;
  assign Dis_is_mem      = head_e.dec.is_mem;
  assign Dis_illegal     = head_e.dec.illegal;
  assign Dis_PC          = head_e.pc;
  assign Dis_BTB_PC      = head_e.btb_pc;
  assign Dis_BTB_predict = head_e.btb_predict;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: instructions are built by an encoder so expected
// dispatch fields are known up front; a queue model tracks the FIFO.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, ROB_clear, IQ_flag;
  logic [31:0] IQ_inst, IQ_PC, IQ_BTB_PC;
  logic        IQ_BTB_predict;
  logic        Dec_flag, Dis_valid, Dis_fire;
  logic [5:0]  Dis_op;
  logic [4:0]  Dis_rd, Dis_rs1, Dis_rs2;
  logic        Dis_R1, Dis_R2;
  logic [31:0] Dis_imm, Dis_PC, Dis_BTB_PC;
  logic        Dis_BTB_predict, Dis_is_mem, Dis_illegal;
  logic        RS_full, LSB_full, ROB_full;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .ROB_clear(ROB_clear),
    .IQ_flag(IQ_flag), .IQ_inst(IQ_inst), .IQ_PC(IQ_PC), .IQ_BTB_PC(IQ_BTB_PC),
    .IQ_BTB_predict(IQ_BTB_predict), .Dec_flag(Dec_flag), .Dis_valid(Dis_valid),
    .Dis_fire(Dis_fire), .Dis_op(Dis_op), .Dis_rd(Dis_rd), .Dis_rs1(Dis_rs1),
    .Dis_rs2(Dis_rs2), .Dis_R1(Dis_R1), .Dis_R2(Dis_R2), .Dis_imm(Dis_imm),
    .Dis_PC(Dis_PC), .Dis_BTB_PC(Dis_BTB_PC), .Dis_BTB_predict(Dis_BTB_predict),
    .Dis_is_mem(Dis_is_mem), .Dis_illegal(Dis_illegal), .RS_full(RS_full),
    .LSB_full(LSB_full), .ROB_full(ROB_full)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic        r1, r2;
    logic [31:0] imm;
    logic        is_mem, illegal;
    logic [31:0] pc, btb;
    logic        pred;
  } exp_t;

  exp_t mq[$];
  exp_t cur_exp;
  int   total = 0;
  int   bad = 0;

  function automatic logic [121:0] pack(exp_t e);
    return {e.op, e.rd, e.rs1, e.rs2, e.r1, e.r2, e.imm, e.is_mem, e.illegal, e.pc, e.btb, e.pred};
  endfunction

  function automatic logic [121:0] obs_head();
    return {Dis_op, Dis_rd, Dis_rs1, Dis_rs2, Dis_R1, Dis_R2, Dis_imm, Dis_is_mem, Dis_illegal,
            Dis_PC, Dis_BTB_PC, Dis_BTB_predict};
  endfunction

  function automatic logic [121:0] exp_head();
    exp_t z;
    z = '{default: '0};
    return (mq.size() != 0) ? pack(mq[0]) : pack(z);
  endfunction

  function automatic logic m_fire();
    if (!rdy_in || rst_in || ROB_clear || ROB_full || mq.size() == 0) return 1'b0;
    return mq[0].is_mem ? !LSB_full : !RS_full;
  endfunction

  function automatic logic m_dec();
    if (!rdy_in || rst_in || ROB_clear || !IQ_flag) return 1'b0;
    return (mq.size() < DEPTH) || m_fire();
  endfunction

  // Advance one clock and apply the queue rules to the model.
  task automatic tick();
    logic f, d;
    @(posedge clk_in);
    f = m_fire();
    d = m_dec();
    if (rst_in || (rdy_in && ROB_clear)) begin
      mq.delete();
    end else begin
      if (f) begin
        $display("dispatch pc=%08h op=%0d mem=%0b", mq[0].pc, mq[0].op, mq[0].is_mem);
        mq.delete(0);
      end
      if (d) mq.push_back(cur_exp);
    end
    #1;
  endtask

  // Encode a random instruction of the given class together with its expected fields.
  task automatic gen(input int kind, output logic [31:0] inst, output exp_t e);
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] i12;
    logic [20:0] j;
    logic [12:0] b;
    int          s;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    r = $urandom; i12 = r[11:0];
    e = '{default: '0};
    inst = '0;
    case (kind)
      0: begin inst = {r[31:12], rd, 7'h37}; e.op = OP_LUI; e.rd = rd; e.imm = {r[31:12], 12'h0}; end
      1: begin inst = {r[31:12], rd, 7'h17}; e.op = OP_AUIPC; e.rd = rd; e.imm = {r[31:12], 12'h0}; end
      2: begin
        j = {r[20:1], 1'b0};
        inst = {j[20], j[10:1], j[11], j[19:12], rd, 7'h6f};
        e.op = OP_JAL; e.rd = rd; e.imm = {{11{j[20]}}, j};
      end
      3: begin
        inst = {i12, rs1, 3'b000, rd, 7'h67};
        e.op = OP_JALR; e.rd = rd; e.rs1 = rs1; e.r1 = 1; e.imm = {{20{i12[11]}}, i12};
      end
      4: begin
        s = $urandom_range(0, 5);
        b = {r[12:1], 1'b0};
        case (s)
          0: begin f3 = 3'd0; e.op = OP_BEQ; end
          1: begin f3 = 3'd1; e.op = OP_BNE; end
          2: begin f3 = 3'd4; e.op = OP_BLT; end
          3: begin f3 = 3'd5; e.op = OP_BGE; end
          4: begin f3 = 3'd6; e.op = OP_BLTU; end
          default: begin f3 = 3'd7; e.op = OP_BGEU; end
        endcase
        inst = {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'h63};
        e.rs1 = rs1; e.rs2 = rs2; e.r1 = 1; e.r2 = 1; e.imm = {{19{b[12]}}, b};
      end
      5: begin
        s = $urandom_range(0, 4);
        case (s)
          0: begin f3 = 3'd0; e.op = OP_LB; end
          1: begin f3 = 3'd1; e.op = OP_LH; end
          2: begin f3 = 3'd2; e.op = OP_LW; end
          3: begin f3 = 3'd4; e.op = OP_LBU; end
          default: begin f3 = 3'd5; e.op = OP_LHU; end
        endcase
        inst = {i12, rs1, f3, rd, 7'h03};
        e.rd = rd; e.rs1 = rs1; e.r1 = 1; e.imm = {{20{i12[11]}}, i12}; e.is_mem = 1;
      end
      6: begin
        s = $urandom_range(0, 2);
        case (s)
          0: begin f3 = 3'd0; e.op = OP_SB; end
          1: begin f3 = 3'd1; e.op = OP_SH; end
          default: begin f3 = 3'd2; e.op = OP_SW; end
        endcase
        inst = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
        e.rs1 = rs1; e.rs2 = rs2; e.r1 = 1; e.r2 = 1; e.imm = {{20{i12[11]}}, i12}; e.is_mem = 1;
      end
      7: begin
        f3 = 3'($urandom);
        e.imm = {{20{i12[11]}}, i12};
        case (f3)
          3'd0: e.op = OP_ADDI;
          3'd2: e.op = OP_SLTI;
          3'd3: e.op = OP_SLTIU;
          3'd4: e.op = OP_XORI;
          3'd6: e.op = OP_ORI;
          3'd7: e.op = OP_ANDI;
          3'd1: begin i12 = {7'h00, i12[4:0]}; e.op = OP_SLLI; e.imm = {27'd0, i12[4:0]}; end
          default: begin
            i12 = {(r[30] ? 7'h20 : 7'h00), i12[4:0]};
            e.op = r[30] ? OP_SRAI : OP_SRLI;
            e.imm = {27'd0, i12[4:0]};
          end
        endcase
        inst = {i12, rs1, f3, rd, 7'h13};
        e.rd = rd; e.rs1 = rs1; e.r1 = 1;
      end
      8: begin
        s = $urandom_range(0, 9);
        case (s)
          0: begin f7 = 7'h00; f3 = 3'd0; e.op = OP_ADD; end
          1: begin f7 = 7'h20; f3 = 3'd0; e.op = OP_SUB; end
          2: begin f7 = 7'h00; f3 = 3'd1; e.op = OP_SLL; end
          3: begin f7 = 7'h00; f3 = 3'd2; e.op = OP_SLT; end
          4: begin f7 = 7'h00; f3 = 3'd3; e.op = OP_SLTU; end
          5: begin f7 = 7'h00; f3 = 3'd4; e.op = OP_XOR; end
          6: begin f7 = 7'h00; f3 = 3'd5; e.op = OP_SRL; end
          7: begin f7 = 7'h20; f3 = 3'd5; e.op = OP_SRA; end
          8: begin f7 = 7'h00; f3 = 3'd6; e.op = OP_OR; end
          default: begin f7 = 7'h00; f3 = 3'd7; e.op = OP_AND; end
        endcase
        inst = {f7, rs2, rs1, f3, rd, 7'h33};
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.r1 = 1; e.r2 = 1;
      end
      default: begin
        s = $urandom_range(0, 2);
        case (s)
          0: inst = 32'hFFFF_FFFF;
          1: inst = {r[31:15], 3'b010, r[11:7], 7'h63};
          default: inst = {7'h01, r[24:7], 7'h33};
        endcase
`ifdef DECODE_ILLEGAL_EN
        e.op = OP_ADDI;
        e.illegal = 1;
`endif
      end
    endcase
  endtask

  task automatic present(input int kind, input logic [31:0] pc);
    logic [31:0] inst;
    exp_t        e;
    gen(kind, inst, e);
    e.pc = pc; e.btb = $urandom; e.pred = 1'($urandom);
    IQ_inst = inst; IQ_PC = pc; IQ_BTB_PC = e.btb; IQ_BTB_predict = e.pred;
    cur_exp = e;
  endtask

  task automatic do_reset();
    rst_in = 1; IQ_flag = 0; ROB_clear = 0; rdy_in = 1;
    tick(); tick();
    rst_in = 0;
  endtask

  task automatic test_reset();
    rst_in = 1; rdy_in = 1; ROB_clear = 0; IQ_flag = 1;
    RS_full = 0; LSB_full = 0; ROB_full = 0;
    present(7, 32'h40);
    tick(); tick();
    @(negedge clk_in);
    total++;
    if ({Dec_flag, Dis_fire, Dis_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got dec/fire/valid=%b want 000", {Dec_flag, Dis_fire, Dis_valid});
    end
    total++;
    if (obs_head() !== '0) begin
      bad++; $display("FAIL reset_head: got %h want 0", obs_head());
    end
    rst_in = 0; IQ_flag = 0;
    tick();
    $display("reset released");
  endtask

  task automatic test_addi();
    do_reset();
    IQ_flag = 1; IQ_inst = 32'h0050_0093; IQ_PC = 32'h0; IQ_BTB_PC = 32'h4; IQ_BTB_predict = 0;
    cur_exp = '{default: '0};
    cur_exp.op = OP_ADDI; cur_exp.rd = 1; cur_exp.r1 = 1; cur_exp.imm = 5; cur_exp.btb = 32'h4;
    @(negedge clk_in);
    total++;
    if (Dis_valid !== 1'b0 || Dec_flag !== 1'b1) begin
      bad++; $display("FAIL addi_push: got valid=%b dec=%b want 0 1", Dis_valid, Dec_flag);
    end
    tick();
    IQ_flag = 0;
    @(negedge clk_in);
    total++;
    if ({Dis_valid, Dis_op, Dis_rd, Dis_imm, Dis_R1, Dis_R2} !== {1'b1, OP_ADDI, 5'd1, 32'd5, 1'b1, 1'b0}) begin
      bad++; $display("FAIL addi_fields: got v=%b op=%0d rd=%0d imm=%h R1=%b R2=%b", Dis_valid, Dis_op, Dis_rd, Dis_imm, Dis_R1, Dis_R2);
    end
    total++;
    if (Dis_fire !== 1'b1) begin
      bad++; $display("FAIL addi_fire: got %b want 1", Dis_fire);
    end
    tick();
  endtask

  task automatic test_store_lsb();
    do_reset();
    LSB_full = 1; RS_full = 0; ROB_full = 0;
    IQ_flag = 1; IQ_inst = 32'hFE20_AE23; IQ_PC = 32'h8; IQ_BTB_PC = 32'hC; IQ_BTB_predict = 0;
    cur_exp = '{default: '0};
    cur_exp.op = OP_SW; cur_exp.rs1 = 1; cur_exp.rs2 = 2; cur_exp.r1 = 1; cur_exp.r2 = 1;
    cur_exp.imm = 32'hFFFF_FFFC; cur_exp.is_mem = 1; cur_exp.pc = 32'h8; cur_exp.btb = 32'hC;
    tick();
    IQ_flag = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_in);
      total++;
      if (Dis_fire !== 1'b0 || Dis_valid !== 1'b1 || Dis_is_mem !== 1'b1) begin
        bad++; $display("FAIL sw_hold: got fire=%b valid=%b mem=%b want 0 1 1", Dis_fire, Dis_valid, Dis_is_mem);
      end
      tick();
    end
    LSB_full = 0;
    @(negedge clk_in);
    total++;
    if (Dis_fire !== 1'b1 || Dis_imm !== 32'hFFFF_FFFC || Dis_rd !== 5'd0 || Dis_rs2 !== 5'd2) begin
      bad++; $display("FAIL sw_fire: got fire=%b imm=%h rd=%0d rs2=%0d", Dis_fire, Dis_imm, Dis_rd, Dis_rs2);
    end
    tick();
  endtask

  task automatic test_full();
    int k;
    do_reset();
    k = 0;
    ROB_full = 1; IQ_flag = 1;
    for (int c = 0; c < 6; c++) begin
      present(7, 32'(k * 4));
      @(negedge clk_in);
      total++;
      if (Dec_flag !== 1'(c < 4)) begin
        bad++; $display("FAIL full_dec[%0d]: got %b want %b", c, Dec_flag, 1'(c < 4));
      end
      if (c < 4) k++;
      tick();
    end
    ROB_full = 0; IQ_flag = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      total++;
      if (Dis_fire !== 1'b1 || Dis_PC !== 32'(c * 4)) begin
        bad++; $display("FAIL drain[%0d]: got fire=%b pc=%h want 1 %h", c, Dis_fire, Dis_PC, 32'(c * 4));
      end
      tick();
    end
    @(negedge clk_in);
    total++;
    if (Dis_valid !== 1'b0) begin
      bad++; $display("FAIL drain_empty: got valid=%b want 0", Dis_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ROB_full = 1; IQ_flag = 1;
    for (int c = 0; c < 4; c++) begin present(8, 32'(c * 4)); tick(); end
    ROB_full = 0;
    present(5, 32'h10);
    LSB_full = 0; RS_full = 0;
    @(negedge clk_in);
    total++;
    if ({Dec_flag, Dis_fire} !== 2'b11 || Dis_PC !== 32'h0) begin
      bad++; $display("FAIL full_pushpop: got dec=%b fire=%b pc=%h want 1 1 0", Dec_flag, Dis_fire, Dis_PC);
    end
    tick();
    ROB_full = 1; present(7, 32'h14);
    @(negedge clk_in);
    total++;
    if (Dec_flag !== 1'b0 || Dis_valid !== 1'b1 || Dis_PC !== 32'h4) begin
      bad++; $display("FAIL still_full: got dec=%b valid=%b pc=%h want 0 1 4", Dec_flag, Dis_valid, Dis_PC);
    end
    tick();
    ROB_full = 0; IQ_flag = 0;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk_in);
      total++;
      if (Dis_fire !== 1'b1 || Dis_PC !== 32'(c * 4)) begin
        bad++; $display("FAIL b2b_drain[%0d]: got fire=%b pc=%h want 1 %h", c, Dis_fire, Dis_PC, 32'(c * 4));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    ROB_full = 1; IQ_flag = 1;
    for (int c = 0; c < 3; c++) begin present(3, 32'(c * 4)); tick(); end
    ROB_full = 0; ROB_clear = 1; present(0, 32'h20);
    @(negedge clk_in);
    total++;
    if ({Dec_flag, Dis_fire} !== 2'b00) begin
      bad++; $display("FAIL flush_cycle: got dec=%b fire=%b want 0 0", Dec_flag, Dis_fire);
    end
    tick();
    ROB_clear = 0; IQ_flag = 0;
    @(negedge clk_in);
    total++;
    if (Dis_valid !== 1'b0 || obs_head() !== '0) begin
      bad++; $display("FAIL flush_empty: got valid=%b head=%h want 0", Dis_valid, obs_head());
    end
    IQ_flag = 1; present(0, 32'h100); ROB_full = 1;
    tick();
    IQ_flag = 0;
    @(negedge clk_in);
    total++;
    if (Dis_valid !== 1'b1 || Dis_PC !== 32'h100) begin
      bad++; $display("FAIL flush_refill: got valid=%b pc=%h want 1 100", Dis_valid, Dis_PC);
    end
    ROB_full = 0;
    tick();
  endtask

  task automatic test_rdy();
    do_reset();
    ROB_full = 1; IQ_flag = 1;
    present(6, 32'h200); tick();
    present(4, 32'h204); tick();
    rdy_in = 0; ROB_full = 0; RS_full = 0; LSB_full = 0; present(2, 32'h208);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_in);
      total++;
      if ({Dec_flag, Dis_fire} !== 2'b00 || Dis_PC !== 32'h200) begin
        bad++; $display("FAIL rdy_low[%0d]: got dec=%b fire=%b pc=%h", c, Dec_flag, Dis_fire, Dis_PC);
      end
      tick();
    end
    rdy_in = 1; IQ_flag = 0;
    @(negedge clk_in);
    total++;
    if (Dis_fire !== 1'b1 || Dis_PC !== 32'h200) begin
      bad++; $display("FAIL rdy_resume: got fire=%b pc=%h want 1 200", Dis_fire, Dis_PC);
    end
    tick(); tick();
  endtask

  task automatic test_illegal();
    do_reset();
    ROB_full = 1; IQ_flag = 1;
    IQ_inst = 32'hFFFF_FFFF; IQ_PC = 32'h300; IQ_BTB_PC = 32'h304; IQ_BTB_predict = 0;
    cur_exp = '{default: '0};
    cur_exp.pc = 32'h300; cur_exp.btb = 32'h304;
`ifdef DECODE_ILLEGAL_EN
    cur_exp.op = OP_ADDI; cur_exp.illegal = 1;
`endif
    tick();
    IQ_flag = 0;
    @(negedge clk_in);
    total++;
    if (obs_head() !== pack(cur_exp)) begin
      bad++; $display("FAIL illegal_head: got op=%0d ill=%b rd=%0d mem=%b want op=%0d ill=%b rd=0 mem=0",
                      Dis_op, Dis_illegal, Dis_rd, Dis_is_mem, cur_exp.op, cur_exp.illegal);
    end
    ROB_full = 0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      IQ_flag   = ($urandom_range(0, 9) < 7);
      ROB_clear = ($urandom_range(0, 19) == 0);
      rst_in    = ($urandom_range(0, 99) == 0);
      RS_full   = ($urandom_range(0, 3) == 0);
      LSB_full  = ($urandom_range(0, 3) == 0);
      ROB_full  = ($urandom_range(0, 3) == 0);
      present($urandom_range(0, 9), {$urandom_range(0, 32'h3FFF), 2'b00});
      @(negedge clk_in);
      total++;
      if (Dec_flag !== m_dec() || Dis_fire !== m_fire() || Dis_valid !== (mq.size() != 0)) begin
        bad++; $display("FAIL rnd_ctl[%0d]: got dec=%b fire=%b valid=%b want %b %b %b", c,
                        Dec_flag, Dis_fire, Dis_valid, m_dec(), m_fire(), mq.size() != 0);
      end
      total++;
      if (obs_head() !== exp_head()) begin
        bad++; $display("FAIL rnd_head[%0d]: got %h want %h", c, obs_head(), exp_head());
      end
      tick();
    end
    rst_in = 0; rdy_in = 1; ROB_clear = 0; IQ_flag = 0;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; ROB_clear = 0; IQ_flag = 0;
    IQ_inst = '0; IQ_PC = '0; IQ_BTB_PC = '0; IQ_BTB_predict = 0;
    RS_full = 0; LSB_full = 0; ROB_full = 0;
    cur_exp = '{default: '0};
    test_reset();
    test_addi();
    test_store_lsb();
    test_full();
    test_back_to_back();
    test_flush();
    test_rdy();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
